// File: rtl/logic_unit_pkg.sv
// ----------------------------------------------------------------------------
// logic_unit_pkg
// Shared types for the iterative logic unit: the 3-bit operation encoding
// and the controller state encoding. Imported by logic_unit_iter and
// logic_slice.
// ----------------------------------------------------------------------------
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,  // RS AND NOT RT
        OP_PASS = 3'b111   // pass RS
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// ----------------------------------------------------------------------------
// logic_slice
// Combinational SLICE-bit bitwise logic unit.
//
// Ports:
//   i_op : operation select (op_e)
//   i_a  : first operand slice
//   i_b  : second operand slice
//   o_y  : result slice
// ----------------------------------------------------------------------------
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  op_e              i_op,
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    output logic [SLICE-1:0] o_y
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves o_y unassigned (no latch).
        o_y = '0;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_NAND: o_y = ~(i_a & i_b);
            OP_XNOR: o_y = ~(i_a ^ i_b);
            OP_ANDN: o_y = i_a & ~i_b;
            OP_PASS: o_y = i_a;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_iter.sv
// ----------------------------------------------------------------------------
// logic_unit_iter
// Iterative bitwise logic unit: computes OP(RS, RT) SLICE bits per cycle
// into a shadow register, then publishes the full result on O with a
// one-cycle DONE pulse.
//
// Parameters:
//   WIDTH : operand/result width (must be a multiple of SLICE)
//   SLICE : bits processed per cycle (SLICE = WIDTH gives a 1-cycle RUN)
//
// Ports:
//   CLK    : clock, rising edge
//   RST    : synchronous active-high reset
//   START  : begin an operation (accepted in IDLE or FIN, ignored in RUN)
//   OP     : operation select, sampled with START
//   RS, RT : operands, sampled with START
//   O      : result of the last completed operation
//   BUSY   : high while in RUN
//   DONE   : one-cycle pulse when O is updated
//   ZERO   : last completed result is all zeros
//   PARITY : XOR of all bits of the last completed result
//
// Configuration macro:
//   LOGIC_UNIT_ITER_FLAGS_EN : when defined, ZERO/PARITY are registered
//                              alongside O; otherwise both are tied to 0.
// ----------------------------------------------------------------------------
module logic_unit_iter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] RS,
    input  logic [WIDTH-1:0] RT,
    output logic [WIDTH-1:0] O,
    output logic             BUSY,
    output logic             DONE,
    output logic             ZERO,
    output logic             PARITY
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
        $error("logic_unit_iter: WIDTH must be a positive multiple of SLICE");
    end

    state_e           r_state;
    state_e           w_state_nxt;
    op_e              r_op;
    logic [WIDTH-1:0] r_rs;
    logic [WIDTH-1:0] r_rt;
    logic [WIDTH-1:0] r_shadow;
    logic [CW-1:0]    r_k;
    logic [WIDTH-1:0] r_o;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [31:0]      w_base;
    logic [SLICE-1:0] w_a;
    logic [SLICE-1:0] w_b;
    logic [SLICE-1:0] w_y;

    // A new operation may be taken from IDLE or, back-to-back, from FIN.
    assign w_accept = START && ((r_state == IDLE) || (r_state == FIN));
    assign w_last   = (r_k == CW'(NSL - 1));
    assign w_base   = 32'(r_k) * 32'(SLICE);
    assign w_a      = r_rs[w_base +: SLICE];
    assign w_b      = r_rt[w_base +: SLICE];

    logic_slice #(.SLICE(SLICE)) u_slice (
        .i_op (r_op),
        .i_a  (w_a),
        .i_b  (w_b),
        .o_y  (w_y)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (START) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = FIN;
            FIN:     w_state_nxt = START ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_op     <= OP_AND;
            r_rs     <= '0;
            r_rt     <= '0;
            r_shadow <= '0;
            r_k      <= '0;
            r_o      <= '0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            // The result lands in O one edge after the last slice is written,
            // so FIN both publishes and may accept the next operation.
            r_done  <= (r_state == FIN);
            if (r_state == FIN) begin
                r_o <= r_shadow;
            end
            if (w_accept) begin
                r_op <= op_e'(OP);
                r_rs <= RS;
                r_rt <= RT;
                r_k  <= '0;
            end else if (r_state == RUN) begin
                r_shadow[w_base +: SLICE] <= w_y;
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign O    = r_o;
    assign DONE = r_done;
    assign BUSY = (r_state == RUN);

`ifdef LOGIC_UNIT_ITER_FLAGS_EN
    logic r_zero;
    logic r_parity;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_zero   <= 1'b1;
            r_parity <= 1'b0;
        end else if (r_state == FIN) begin
            r_zero   <= ~|r_shadow;
            r_parity <= ^r_shadow;
        end
    end

    assign ZERO   = r_zero;
    assign PARITY = r_parity;
`else
    assign ZERO   = 1'b0;
    assign PARITY = 1'b0;
`endif

endmodule
